// File: rtl/full_st1_data_in_pkg.sv
// Shared types and defaults for the fully-connected stage-1 input buffer.
package full_st1_data_in_pkg;

    localparam int DEF_DEPTH     = 8;
    localparam int DEF_FRAME_LEN = 6;
    localparam int DEF_CNT_W     = 16;

    // 24-bit mantissa / 8-bit exponent float carried as an opaque 32-bit word
    typedef logic [31:0] float_24_8_t;

    // One buffered stream word: frame-start marker plus payload
    typedef struct packed {
        logic        fst;
        float_24_8_t data;
    } stream_entry_t;

    // Width of a counter over 0..n-1, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/full_st1_data_in_if.sv
// Valid/ready stream of float_24_8 words with a frame-start flag and an
// almost-full hint travelling back towards the source.
interface full_st1_data_in_if;
    import full_st1_data_in_pkg::*;

    float_24_8_t data;
    logic        fst;
    logic        vld;
    logic        rdy;
    logic        pre_rdy;

    modport master (output data, output fst, output vld, input rdy, input pre_rdy);
    modport slave  (input data, input fst, input vld, output rdy, output pre_rdy);

endinterface

// File: rtl/full_st1_data_in_stage_fifo_ctrl.sv
// Pointer/occupancy bookkeeping for the FWFT input FIFO. Flow-control outputs
// depend only on registered occupancy, so out_rdy never reaches in_rdy.
module stage_fifo_ctrl #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_vld,
    input  logic                     out_rdy,
    output logic                     in_rdy,
    output logic                     in_pre_rdy,
    output logic                     out_vld,
    output logic                     push,
    output logic                     pop,
    output logic [$clog2(DEPTH)-1:0] wr_ptr,
    output logic [$clog2(DEPTH)-1:0] rd_ptr,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] PRE_LVL  = (PTR_W + 1)'(DEPTH - 2);

    // Handshakes and flow-control flags derived from the current occupancy
    always_comb begin
        in_rdy     = (level != FULL_LVL);
        in_pre_rdy = (level <= PRE_LVL);
        out_vld    = (level != '0);
        push       = in_vld & in_rdy;
        pop        = out_vld & out_rdy;
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/full_st1_data_in.sv
// Input buffer for fully-connected stage 1: FWFT FIFO between the stage-0
// forward stream and the stage-1 controller, plus a frame-length checker.
module full_st1_data_in
    import full_st1_data_in_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    full_st1_data_in_if.slave      in_s,
    full_st1_data_in_if.master     out_s,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_W-1:0]       frame_cnt,
    output logic                   frame_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int IDX_W = idx_width(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    logic             push;
    logic             pop;
    logic             out_vld;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    stream_entry_t    mem [DEPTH];

    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic             short_err;
    logic             long_err;

    stage_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk        (clk),
        .reset      (reset),
        .in_vld     (in_s.vld),
        .out_rdy    (out_s.rdy),
        .in_rdy     (in_s.rdy),
        .in_pre_rdy (in_s.pre_rdy),
        .out_vld    (out_vld),
        .push       (push),
        .pop        (pop),
        .wr_ptr     (wr_ptr),
        .rd_ptr     (rd_ptr),
        .level      (level)
    );

    // Storage is cleared on reset so the head word reads zero while empty
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= '{fst: in_s.fst, data: in_s.data};
        end
    end

    // First-word-fall-through: the head entry is always on the output
    always_comb begin
        out_s.data = mem[rd_ptr].data;
        out_s.fst  = mem[rd_ptr].fst;
        out_s.vld  = out_vld;
    end

    // Frame alignment rules; nothing is judged until the first fst has been seen
    always_comb begin
        short_err = push & in_s.fst & (idx != '0) & (frame_cnt != '0);
        long_err  = push & ~in_s.fst & (idx == '0) & (frame_cnt != '0);
        if (in_s.fst) begin
            idx_next = (FRAME_LEN == 1) ? '0 : IDX_W'(1);
        end else begin
            idx_next = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

    // Input-side frame position, frame counter and sticky error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            idx       <= '0;
            frame_cnt <= '0;
            frame_err <= 1'b0;
        end else if (push) begin
            idx <= idx_next;
            if (in_s.fst) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (short_err | long_err) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_full_st1_data_in.sv
// Scoreboard bench for full_st1_data_in: directed frame/flow-control scenarios
// followed by a randomized valid/ready run against a queue-based model.
`timescale 1ns/1ps
module tb_full_st1_data_in;

    localparam int DEPTH     = 8;
    localparam int FRAME_LEN = 6;
    localparam int CNT_W     = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [3:0]       level;
    logic [CNT_W-1:0] frame_cnt;
    logic             frame_err;

    full_st1_data_in_if in_if ();
    full_st1_data_in_if out_if ();

    assign out_if.pre_rdy = 1'b1;

    full_st1_data_in #(
        .DEPTH     (DEPTH),
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_s      (in_if.slave),
        .out_s     (out_if.master),
        .level     (level),
        .frame_cnt (frame_cnt),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [32:0] exp_q [$];
    int          model_pos;
    int          model_frames;
    bit          model_err;
    bit          in_reset = 1'b1;
    bit          rand_rdy = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Frame rules expressed as words-since-last-fst, checked modulo the frame length
    task automatic modelAccept(input logic [31:0] d, input logic f);
        exp_q.push_back({f, d});
        if (model_frames != 0) begin
            if (f && (model_pos % FRAME_LEN) != 0) model_err = 1'b1;
            if (!f && (model_pos % FRAME_LEN) == 0) model_err = 1'b1;
        end
        if (f) begin
            model_pos = 1;
            model_frames = (model_frames + 1) % (1 << CNT_W);
        end else begin
            model_pos++;
        end
    endtask

    // Offer one word for up to max_cycles clocks; called and returns at a falling edge
    task automatic applyStimulus(input logic [31:0] d, input logic f, input int max_cycles, output bit accepted);
        accepted = 1'b0;
        for (int c = 0; c < max_cycles && !accepted; c++) begin
            in_if.data = d;
            in_if.fst  = f;
            in_if.vld  = 1'b1;
            #2;
            if (in_if.rdy) begin
                modelAccept(d, f);
                accepted = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_if.vld = 1'b0;
    endtask

    task automatic doReset;
        in_reset  = 1'b1;
        reset     = 1'b1;
        in_if.vld = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        model_pos    = 0;
        model_frames = 0;
        model_err    = 1'b0;
        in_reset     = 1'b0;
        #1;
        checkOutput("rst_level", 64'(level), 64'd0);
        checkOutput("rst_out_vld", 64'(out_if.vld), 64'd0);
        checkOutput("rst_out_data", 64'(out_if.data), 64'd0);
        checkOutput("rst_out_fst", 64'(out_if.fst), 64'd0);
        checkOutput("rst_in_rdy", 64'(in_if.rdy), 64'd1);
        checkOutput("rst_in_pre_rdy", 64'(in_if.pre_rdy), 64'd1);
        checkOutput("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        checkOutput("rst_frame_err", 64'(frame_err), 64'd0);
        @(negedge clk);
    endtask

    // Random output back-pressure during the soak phase
    always @(negedge clk) begin
        if (rand_rdy) out_if.rdy = ($urandom_range(0, 3) != 0);
    end

    // Monitor: compares occupancy, flags and head word to the model, pops on handshake
    always begin
        @(negedge clk);
        #1;
        if (!in_reset) begin
            checkOutput("level", 64'(level), 64'(exp_q.size()));
            checkOutput("in_rdy", 64'(in_if.rdy), 64'(exp_q.size() != DEPTH));
            checkOutput("in_pre_rdy", 64'(in_if.pre_rdy), 64'(exp_q.size() <= DEPTH - 2));
            checkOutput("out_vld", 64'(out_if.vld), 64'(exp_q.size() != 0));
            checkOutput("frame_cnt", 64'(frame_cnt), 64'(model_frames));
            checkOutput("frame_err", 64'(frame_err), 64'(model_err));
            if (out_if.vld && exp_q.size() != 0) begin
                checkOutput("out_data", 64'(out_if.data), 64'(exp_q[0][31:0]));
                checkOutput("out_fst", 64'(out_if.fst), 64'(exp_q[0][32]));
                if (out_if.rdy) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        bit ok;
        int pos;
        logic f;
        in_if.data = '0;
        in_if.fst  = 1'b0;
        in_if.vld  = 1'b0;
        out_if.rdy = 1'b0;
        @(negedge clk);
        doReset();

        // Test 1: one clean frame streamed straight through
        out_if.rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(32'h3F80_0000 + 32'(i), (i == 0), 4, ok);
            checkOutput("t1_accept", 64'(ok), 64'd1);
        end
        @(negedge clk);
        checkOutput("t1_frame_cnt", 64'(frame_cnt), 64'd1);
        checkOutput("t1_frame_err", 64'(frame_err), 64'd0);

        // Test 2: stalled output, fill until blocked
        out_if.rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(32'h4000_0000 + 32'(i), (i % 6 == 0), 1, ok);
            checkOutput("t2_accept", 64'(ok), 64'd1);
        end
        applyStimulus(32'h4000_0008, 1'b0, 3, ok);
        checkOutput("t2_ninth_held", 64'(ok), 64'd0);
        checkOutput("t2_head_word", 64'(out_if.data), 64'h4000_0000);

        // Test 3: full with both sides active; pop first, push one cycle later
        out_if.rdy = 1'b1;
        applyStimulus(32'h4000_0008, 1'b0, 2, ok);
        checkOutput("t3_push_second_cycle", 64'(ok), 64'd1);
        #1;
        checkOutput("t3_level", 64'(level), 64'd7);
        @(negedge clk);
        for (int i = 9; i < 12; i++) begin
            applyStimulus(32'h4000_0000 + 32'(i), 1'b0, 4, ok);
        end
        repeat (10) @(negedge clk);

        // Test 4: premature fst on word 3
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'h5000_0000 + 32'(i), (i == 0 || i == 3), 4, ok);
            #1;
            checkOutput("t4_frame_err", 64'(frame_err), 64'(i == 3));
            @(negedge clk);
        end
        checkOutput("t4_frame_cnt", 64'(frame_cnt), 64'd5);
        repeat (3) @(negedge clk);
        checkOutput("t4_err_sticky", 64'(frame_err), 64'd1);

        // Test 5: long frame, seventh word without a new fst
        doReset();
        for (int i = 0; i < 7; i++) begin
            applyStimulus(32'h6000_0000 + 32'(i), (i == 0), 4, ok);
            #1;
            checkOutput("t5_frame_err", 64'(frame_err), 64'(i == 6));
            @(negedge clk);
        end

        // Test 6: reset while holding five words
        doReset();
        out_if.rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(32'h7000_0000 + 32'(i), (i == 0), 2, ok);
        end
        #1;
        checkOutput("t6_level_before", 64'(level), 64'd5);
        @(negedge clk);
        doReset();

        // Random soak: mostly well-formed frames with occasional misplaced fst
        rand_rdy = 1'b1;
        pos = 0;
        for (int n = 0; n < 10000; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            f = (pos % FRAME_LEN == 0);
            if ($urandom_range(0, 99) < 3) f = ~f;
            applyStimulus($urandom, f, 100, ok);
            if (!ok) begin
                checkOutput("rand_accept_timeout", 64'(ok), 64'd1);
                break;
            end
            pos = f ? 1 : pos + 1;
        end
        rand_rdy   = 1'b0;
        out_if.rdy = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
        checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
